// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : 6502 instruction fetch stage (opcode + 0-2 operands, PC)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  output logic [15:0] mem_addr,
  output logic        mem_rd_req,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_rd_valid,
  input  logic        next_instr,
  input  logic        load_PC,
  input  logic [15:0] pc_in,
  output logic [7:0]  opcode,
  output logic [7:0]  operand_lo,
  output logic [7:0]  operand_hi,
  output logic [1:0]  instr_len,
  output logic        instr_valid,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_OP = 3'd1,
    S_FETCH_LO = 3'd2,
    S_FETCH_HI = 3'd3,
    S_READY    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [7:0]  r_opcode;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [1:0]  r_len;
  logic        w_req;
  logic        w_accept;
  logic        w_load;
  logic [1:0]  w_dec_len;

  // Length decode covers all 256 codes, unofficial ones included.
  function automatic logic [1:0] f_len(input logic [7:0] op);
    logic [3:0] lo_n;
    logic [3:0] hi_n;
    lo_n = op[3:0];
    hi_n = op[7:4];
    if (op == 8'h20)
      f_len = 2'd3;
    else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
      f_len = 2'd1;
    else if (lo_n == 4'h8 || lo_n == 4'hA)
      f_len = 2'd1;
    else if (lo_n >= 4'hC)
      f_len = 2'd3;
    else if ((lo_n == 4'h9 || lo_n == 4'hB) && hi_n[0])
      f_len = 2'd3;
    else
      f_len = 2'd2;
  endfunction

  assign w_dec_len = f_len(mem_rd_data);
  assign w_req     = (r_state == S_FETCH_OP) || (r_state == S_FETCH_LO) ||
                     (r_state == S_FETCH_HI);
  assign w_accept  = w_req & mem_rd_valid & rdy;
  assign w_load    = rdy & load_PC & ((r_state == S_IDLE) || (r_state == S_READY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else if (rdy)
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!load_PC)
          w_state_next = S_FETCH_OP;
      end
      S_FETCH_OP: begin
        if (w_accept)
          w_state_next = (w_dec_len == 2'd1) ? S_READY : S_FETCH_LO;
      end
      S_FETCH_LO: begin
        if (w_accept)
          w_state_next = (r_len == 2'd2) ? S_READY : S_FETCH_HI;
      end
      S_FETCH_HI: begin
        if (w_accept)
          w_state_next = S_READY;
      end
      S_READY: begin
        if (load_PC)
          w_state_next = S_IDLE;
        else if (next_instr)
          w_state_next = S_FETCH_OP;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Reset drops any in-flight byte; unfetched operands keep old values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= PC_RESET;
      r_opcode <= 8'hEA;
      r_lo     <= 8'h00;
      r_hi     <= 8'h00;
      r_len    <= 2'd1;
    end else begin
      if (w_load)
        r_pc <= pc_in;
      else if (w_accept)
        r_pc <= r_pc + 16'd1;

      if (w_accept) begin
        case (r_state)
          S_FETCH_OP: begin
            r_opcode <= mem_rd_data;
            r_len    <= w_dec_len;
          end
          S_FETCH_LO: r_lo <= mem_rd_data;
          S_FETCH_HI: r_hi <= mem_rd_data;
          default: ;
        endcase
      end
    end
  end

  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign mem_rd_req  = w_req;
  assign opcode      = r_opcode;
  assign operand_lo  = r_lo;
  assign operand_hi  = r_hi;
  assign instr_len   = r_len;
  assign instr_valid = (r_state == S_READY);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        rdy;
  logic [15:0] mem_addr;
  logic        mem_rd_req;
  logic [7:0]  mem_rd_data;
  logic        mem_rd_valid;
  logic        next_instr;
  logic        load_PC;
  logic [15:0] pc_in;
  logic [7:0]  opcode;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic [15:0] pc;

  logic [7:0]  mem [0:65535];
  int          wcnt;
  int          wait_n;
  logic        mem_hold;
  int          n_cmp;
  int          n_err;
  logic [1:0]  got_len [0:255];

  instr_fetch #(.PC_RESET(16'h0200)) dut (
    .clk          (clk),
    .reset        (reset),
    .rdy          (rdy),
    .mem_addr     (mem_addr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .next_instr   (next_instr),
    .load_PC      (load_PC),
    .pc_in        (pc_in),
    .opcode       (opcode),
    .operand_lo   (operand_lo),
    .operand_hi   (operand_hi),
    .instr_len    (instr_len),
    .instr_valid  (instr_valid),
    .pc           (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: wait_n stall cycles per byte, frozen while rdy is low.
  assign mem_rd_data  = mem[mem_addr];
  assign mem_rd_valid = mem_rd_req && !mem_hold && (wcnt >= wait_n);

  always @(posedge clk or posedge reset) begin
    if (reset)
      wcnt <= 0;
    else if (!mem_rd_req || (mem_rd_valid && rdy))
      wcnt <= 0;
    else if (rdy)
      wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    if (op == 8'h20) return 2'd3;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
    if (op[3:0] == 4'h8 || op[3:0] == 4'hA) return 2'd1;
    if (op[3:0] >= 4'hC) return 2'd3;
    if ((op[3:0] == 4'h9 || op[3:0] == 4'hB) && op[4]) return 2'd3;
    return 2'd2;
  endfunction

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!instr_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},     {16'd0, pc},         32'h0200);
    check({tag, "_addr"},   {16'd0, mem_addr},   32'h0200);
    check({tag, "_req"},    {31'd0, mem_rd_req}, 32'd0);
    check({tag, "_valid"},  {31'd0, instr_valid},32'd0);
    check({tag, "_opcode"}, {24'd0, opcode},     32'hEA);
    check({tag, "_lo"},     {24'd0, operand_lo}, 32'h00);
    check({tag, "_hi"},     {24'd0, operand_hi}, 32'h00);
    check({tag, "_len"},    {30'd0, instr_len},  32'd1);
  endtask

  initial begin
    int cyc;
    logic stalled;
    logic [15:0] b;
    logic [7:0] ex_op [0:5];
    logic [1:0] ex_len [0:5];

    n_cmp = 0; n_err = 0;
    reset = 1'b1; rdy = 1'b1; next_instr = 1'b0; load_PC = 1'b0;
    pc_in = 16'h0000; wait_n = 0; mem_hold = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hEA;
    mem[16'h0201] = 8'hAD; mem[16'h0202] = 8'h34; mem[16'h0203] = 8'h12;
    mem[16'h0204] = 8'hAD; mem[16'h0205] = 8'h34; mem[16'h0206] = 8'h12;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h55;
    mem[16'h5000] = 8'hAD; mem[16'h5001] = 8'h77; mem[16'h5002] = 8'h88;
    for (int c = 0; c < 256; c++) begin
      b = 16'h4000 + 16'(c * 4);
      mem[b] = 8'(c); mem[b + 16'd1] = 8'h11; mem[b + 16'd2] = 8'h22;
    end

    // Reset values, then the first fetch of a 1-byte NOP
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check("t1_req", {31'd0, mem_rd_req}, 32'd1);
    check("t1_addr", {16'd0, mem_addr}, 32'h0200);
    @(negedge clk);
    check("t1_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_opcode", {24'd0, opcode}, 32'hEA);
    check("t1_len", {30'd0, instr_len}, 32'd1);
    check("t1_pc", {16'd0, pc}, 32'h0201);

    // Zero-wait 3-byte fetch
    next_instr = 1'b1;
    @(negedge clk); next_instr = 1'b0;
    check("t2_addr0", {16'd0, mem_addr}, 32'h0201);
    check("t2_req", {31'd0, mem_rd_req}, 32'd1);
    @(negedge clk);
    check("t2_addr1", {16'd0, mem_addr}, 32'h0202);
    @(negedge clk);
    check("t2_addr2", {16'd0, mem_addr}, 32'h0203);
    check("t2_notvalid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_opcode", {24'd0, opcode}, 32'hAD);
    check("t2_lo", {24'd0, operand_lo}, 32'h34);
    check("t2_hi", {24'd0, operand_hi}, 32'h12);
    check("t2_len", {30'd0, instr_len}, 32'd3);
    check("t2_pc", {16'd0, pc}, 32'h0204);

    // Two wait cycles per byte plus a 3-cycle rdy stall in FETCH_LO
    wait_n = 2;
    next_instr = 1'b1;
    @(negedge clk); next_instr = 1'b0;
    cyc = 1; stalled = 1'b0;
    while (!instr_valid && cyc < 60) begin
      if (mem_addr == 16'h0205 && !stalled) begin
        stalled = 1'b1;
        rdy = 1'b0;
        repeat (3) begin
          @(negedge clk); cyc++;
          check("t3_stall_addr", {16'd0, mem_addr}, 32'h0205);
          check("t3_stall_req", {31'd0, mem_rd_req}, 32'd1);
          check("t3_stall_lo", {24'd0, operand_lo}, 32'h34);
        end
        rdy = 1'b1;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("t3_latency", cyc, 32'd13);
    check("t3_opcode", {24'd0, opcode}, 32'hAD);
    check("t3_lo", {24'd0, operand_lo}, 32'h34);
    check("t3_hi", {24'd0, operand_hi}, 32'h12);
    check("t3_len", {30'd0, instr_len}, 32'd3);
    check("t3_pc", {16'd0, pc}, 32'h0207);
    wait_n = 0;

    // load_PC beats next_instr; PC wraps FFFF -> 0000
    load_PC = 1'b1; next_instr = 1'b1; pc_in = 16'hFFFF;
    @(negedge clk); load_PC = 1'b0; next_instr = 1'b0;
    check("t4_idle_req", {31'd0, mem_rd_req}, 32'd0);
    check("t4_idle_valid", {31'd0, instr_valid}, 32'd0);
    check("t4_pc", {16'd0, pc}, 32'hFFFF);
    @(negedge clk);
    check("t4_addr0", {16'd0, mem_addr}, 32'hFFFF);
    @(negedge clk);
    check("t4_addr1", {16'd0, mem_addr}, 32'h0000);
    @(negedge clk);
    check("t4_valid", {31'd0, instr_valid}, 32'd1);
    check("t4_opcode", {24'd0, opcode}, 32'hA9);
    check("t4_lo", {24'd0, operand_lo}, 32'h55);
    check("t4_hi_kept", {24'd0, operand_hi}, 32'h12);
    check("t4_len", {30'd0, instr_len}, 32'd2);
    check("t4_pc_end", {16'd0, pc}, 32'h0001);

    // Length sweep over all opcodes
    for (int c = 0; c < 256; c++) begin
      b = 16'h4000 + 16'(c * 4);
      load_PC = 1'b1; pc_in = b;
      @(negedge clk); load_PC = 1'b0;
      @(negedge clk);
      wait_valid(10);
      got_len[c] = instr_len;
      check("sweep_len", {30'd0, instr_len}, {30'd0, ref_len(8'(c))});
      check("sweep_pc", {16'd0, pc}, {16'd0, b + {14'd0, ref_len(8'(c))}});
    end
    ex_op[0] = 8'h20; ex_len[0] = 2'd3;
    ex_op[1] = 8'h60; ex_len[1] = 2'd1;
    ex_op[2] = 8'h19; ex_len[2] = 2'd3;
    ex_op[3] = 8'h09; ex_len[3] = 2'd2;
    ex_op[4] = 8'h0A; ex_len[4] = 2'd1;
    ex_op[5] = 8'hA2; ex_len[5] = 2'd2;
    for (int k = 0; k < 6; k++)
      check("sweep_example", {30'd0, got_len[ex_op[k]]}, {30'd0, ex_len[k]});

    // Control inputs ignored in FETCH_LO; reset mid FETCH_HI
    load_PC = 1'b1; pc_in = 16'h5000;
    @(negedge clk); load_PC = 1'b0;
    @(negedge clk);
    check("t6_addr_op", {16'd0, mem_addr}, 32'h5000);
    @(negedge clk);
    check("t6_addr_lo", {16'd0, mem_addr}, 32'h5001);
    mem_hold = 1'b1; load_PC = 1'b1; pc_in = 16'h1234; next_instr = 1'b1;
    @(negedge clk); load_PC = 1'b0; next_instr = 1'b0;
    check("t6_ign_addr", {16'd0, mem_addr}, 32'h5001);
    check("t6_ign_pc", {16'd0, pc}, 32'h5001);
    check("t6_ign_req", {31'd0, mem_rd_req}, 32'd1);
    check("t6_ign_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_ign_opcode", {24'd0, opcode}, 32'hAD);
    check("t6_ign_lo", {24'd0, operand_lo}, 32'h11);
    check("t6_ign_len", {30'd0, instr_len}, 32'd3);
    @(negedge clk);
    check("t6_hold_addr", {16'd0, mem_addr}, 32'h5001);
    mem_hold = 1'b0;
    @(negedge clk);
    check("t6_addr_hi", {16'd0, mem_addr}, 32'h5002);
    check("t6_lo", {24'd0, operand_lo}, 32'h77);
    mem_hold = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    check("t6_restart_req", {31'd0, mem_rd_req}, 32'd1);
    check("t6_restart_addr", {16'd0, mem_addr}, 32'h0200);
    @(negedge clk);
    check("t6_restart_valid", {31'd0, instr_valid}, 32'd1);
    check("t6_restart_op", {24'd0, opcode}, 32'hEA);
    check("t6_restart_pc", {16'd0, pc}, 32'h0201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
